// File: rtl/featuremap_pad_writer_pkg.sv
// Shared types and constants for the zero-padding feature-map FIFO writer.
// The state enum doubles as the debug encoding seen on dbg_state.
package featuremap_pad_writer_pkg;

  localparam int FM_DATA_WIDTH = 32;

  // IEEE-754 single-precision +0.0 used for every border word.
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/featuremap_pad_writer_if.sv
// Upstream pixel stream plus downstream FIFO write port of one padding writer.
// The writer holds the master modport; the environment holds the slave one.
interface featuremap_pad_writer_if
  import featuremap_pad_writer_pkg::*;
#(
  parameter int DATA_WIDTH = FM_DATA_WIDTH
);

  // Upstream: a pixel transfers in any cycle where valid_in & ready_in, and
  // data_in must stay stable while valid_in is high and ready_in is low.
  // Downstream: a word is written in every cycle where wrreq is high; wrreq is
  // never raised while fifo_full is high.
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic                  ready_in;
  logic                  fifo_full;
  logic                  wrreq;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  data_in,
    input  valid_in,
    input  fifo_full,
    output ready_in,
    output wrreq,
    output data_out
  );

  modport slave (
    output data_in,
    output valid_in,
    output fifo_full,
    input  ready_in,
    input  wrreq,
    input  data_out
  );

endinterface

// File: rtl/featuremap_pad_writer_counter.sv
// Row/column position inside the padded (HEIGHT+2)x(WIDTH+2) frame.
// Advances one column per written word and flags border and final positions.
module featuremap_pad_counter
  import featuremap_pad_writer_pkg::*;
#(
  parameter int WIDTH  = 56,
  parameter int HEIGHT = 56
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output logic border,
  output logic last
);

  localparam int COL_W = ctr_width(WIDTH + 2);
  localparam int ROW_W = ctr_width(HEIGHT + 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT + 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (advance) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        // Wrap the row after the final word so the next frame starts at origin.
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  always_comb begin
    border = (row_q == '0) || (row_q == ROW_LAST) ||
             (col_q == '0) || (col_q == COL_LAST);
    last   = (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

endmodule

// File: rtl/featuremap_pad_writer.sv
// Wraps one channel's raster in a one-pixel ring of +0.0 and writes the padded
// frame into the feature-map FIFO in raster order, one word per write.
module featuremap_pad_writer
  import featuremap_pad_writer_pkg::*;
#(
  parameter int DATA_WIDTH = FM_DATA_WIDTH,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  featuremap_pad_writer_if.master        bus,
  output logic                           busy,
  output logic                           frame_done,
  output state_t                         dbg_state
);

  state_t state_q, state_d;
  logic   busy_q, busy_d;
  logic   frame_done_q, frame_done_d;

  logic   streaming;
  logic   border;
  logic   last;
  logic   clear;
  logic   write_en;

  featuremap_pad_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (write_en),
    .border  (border),
    .last    (last)
  );

  // Border words never wait for upstream; interior words need a valid pixel.
  always_comb begin
    streaming = (state_q == ST_STREAM);
    write_en  = streaming && !bus.fifo_full && (border || bus.valid_in);
  end

  assign bus.wrreq    = write_en;
  assign bus.ready_in = streaming && !border && !bus.fifo_full;
  assign bus.data_out = (streaming && !border) ? bus.data_in : DATA_WIDTH'(FP32_ZERO);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    clear        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
          busy_d  = 1'b1;
          clear   = 1'b1;
        end
      end
      ST_STREAM: begin
        if (write_en && last) begin
          state_d      = ST_DONE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Bench for featuremap_pad_writer at WIDTH=4, HEIGHT=3: scenario table, hand
// sequences for reset and start corner cases, and a frame-level reference model.
module tb_featuremap_pad_writer;
  import featuremap_pad_writer_pkg::*;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int TOTAL = (W + 2) * (H + 2);
  localparam int NPIX  = W * H;

  logic   clk;
  logic   rst;
  logic   start;
  logic   busy;
  logic   frame_done;
  state_t dbg_state;

  featuremap_pad_writer_if #(.DATA_WIDTH(32)) fif ();

  featuremap_pad_writer #(
    .DATA_WIDTH (32),
    .WIDTH      (W),
    .HEIGHT     (H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (fif),
    .busy       (busy),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int vmode;      // 0: valid always, 1: toggling, 2: random
    int full_at;    // word index at which a 5-cycle full stall begins, -1 none
    bit rand_full;
    bit fixed_pix;  // pixels 1.0..12.0 instead of random words
    int exp_writes;
    int exp_pixels;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] fp_lut[NPIX];
  logic [31:0] gold[TOTAL];
  logic [31:0] wlog[TOTAL];
  logic [31:0] pix[NPIX];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level reference model state.
  bit m_active;
  int m_wr;
  int m_since;
  int m_frames;
  int n_writes, n_consumed, n_done;

  // Driver state.
  int vmode, full_at, full_cnt, up_idx;
  bit rand_full, full_done, restart_up, start_next;
  logic last_full;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_border(input int w);
    int r, c;
    r = w / (W + 2);
    c = w % (W + 2);
    return (r == 0) || (r == H + 1) || (c == 0) || (c == W + 1);
  endfunction

  task automatic check_cycle();
    bit   idle_now, bord;
    int   n;
    logic [31:0] ew;
    if (!m_active && m_since < 50) m_since++;
    idle_now = !m_active && (m_since >= 2);
    chk("busy", busy, m_active);
    chk("frame_done", frame_done, m_since == 1);
    if (frame_done) n_done++;
    if (fif.valid_in && fif.ready_in) begin
      n_consumed++;
      chk("accept_writes", fif.wrreq, 1'b1);
    end
    if (!m_active) begin
      chk("idle_wrreq", fif.wrreq, 1'b0);
      chk("idle_ready", fif.ready_in, 1'b0);
      chk("idle_data", fif.data_out, 32'h0);
    end else begin
      bord = is_border(m_wr);
      chk("wrreq", fif.wrreq, !fif.fifo_full && (bord || fif.valid_in));
      chk("ready_in", fif.ready_in, !bord && !fif.fifo_full);
      if (fif.wrreq) begin
        ew = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("data_out", fif.data_out, ew);
        if (m_wr == full_at) chk("stall_release", last_full, 1'b1);
        wlog[m_wr] = fif.data_out;
        m_wr++;
        n_writes++;
        if (m_wr == TOTAL) begin
          m_active = 1'b0;
          m_since  = 0;
          m_frames++;
        end
      end
    end
    if (start && idle_now) begin
      m_active = 1'b1;
      m_wr     = 0;
      restart_up = 1'b1;
      exp_q.delete();
      n = 0;
      for (int w = 0; w < TOTAL; w++) begin
        if (is_border(w)) exp_q.push_back(32'h0);
        else begin
          exp_q.push_back(pix[n]);
          n++;
        end
      end
    end
    last_full = fif.fifo_full;
  endtask

  task automatic step();
    logic acc;
    @(negedge clk);
    check_cycle();
    acc = fif.valid_in & fif.ready_in;
    @(posedge clk);
    #1;
    if (restart_up) begin
      up_idx     = 0;
      restart_up = 1'b0;
    end else if (acc) begin
      up_idx++;
    end
    case (vmode)
      0:       fif.valid_in = 1'b1;
      1:       fif.valid_in = ~fif.valid_in;
      default: fif.valid_in = 1'($urandom_range(0, 1));
    endcase
    fif.data_in = (up_idx < NPIX) ? pix[up_idx] : $urandom();
    if (full_cnt > 0) begin
      fif.fifo_full = 1'b1;
      full_cnt--;
    end else if (full_at >= 0 && m_active && m_wr == full_at && !full_done) begin
      fif.fifo_full = 1'b1;
      full_cnt      = 4;
      full_done     = 1'b1;
    end else if (rand_full) begin
      fif.fifo_full = ($urandom_range(0, 3) == 0);
    end else begin
      fif.fifo_full = 1'b0;
    end
    start      = start_next;
    start_next = 1'b0;
  endtask

  task automatic setup(input vec_t v);
    vmode     = v.vmode;
    full_at   = v.full_at;
    rand_full = v.rand_full;
    full_done = 1'b0;
    full_cnt  = 0;
    for (int i = 0; i < NPIX; i++) pix[i] = v.fixed_pix ? fp_lut[i] : $urandom();
    for (int i = 0; i < TOTAL; i++) wlog[i] = 32'hFFFF_FFFF;
    n_writes   = 0;
    n_consumed = 0;
    n_done     = 0;
  endtask

  task automatic wait_frames(input int target);
    int i;
    i = 0;
    while (m_frames < target && i < 800) begin
      step();
      i++;
    end
    chk("frame_complete", m_frames, target);
  endtask

  task automatic check_gold(input string tag);
    for (int i = 0; i < TOTAL; i++) chk({tag, "_word"}, wlog[i], gold[i]);
  endtask

  task automatic run_frame(input vec_t v);
    int f0;
    setup(v);
    f0 = m_frames;
    start_next = 1'b1;
    wait_frames(f0 + 1);
    step();
    step();
    chk("frame_writes", n_writes, v.exp_writes);
    chk("frame_pixels", n_consumed, v.exp_pixels);
    chk("frame_done_count", n_done, 1);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("busy_after", busy, 1'b0);
    if (v.fixed_pix) check_gold("frame");
  endtask

  initial begin
    int i, f0;
    fp_lut = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
               32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000,
               32'h4110_0000, 32'h4120_0000, 32'h4130_0000, 32'h4140_0000};
    for (int r = 0; r < H + 2; r++)
      for (int c = 0; c < W + 2; c++)
        gold[r * (W + 2) + c] = (r >= 1 && r <= H && c >= 1 && c <= W)
                                ? fp_lut[(r - 1) * W + (c - 1)] : 32'h0;
    vecs[0] = '{0, -1, 1'b0, 1'b1, TOTAL, NPIX};
    vecs[1] = '{1, -1, 1'b0, 1'b1, TOTAL, NPIX};
    vecs[2] = '{0,  8, 1'b0, 1'b1, TOTAL, NPIX};
    vecs[3] = '{2, -1, 1'b1, 1'b0, TOTAL, NPIX};
    vecs[4] = '{1, -1, 1'b1, 1'b0, TOTAL, NPIX};

    m_active = 1'b0; m_wr = 0; m_since = 50; m_frames = 0;
    vmode = 0; full_at = -1; full_cnt = 0; up_idx = 0;
    rand_full = 1'b0; full_done = 1'b0; restart_up = 1'b0; start_next = 1'b0;
    last_full = 1'b0;
    for (int k = 0; k < NPIX; k++) pix[k] = fp_lut[k];

    rst = 1'b0; start = 1'b0;
    fif.valid_in = 1'b0; fif.data_in = 32'h0; fif.fifo_full = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_wrreq", fif.wrreq, 1'b0);
    chk("rst_ready", fif.ready_in, 1'b0);
    chk("rst_data", fif.data_out, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;

    // Valid upstream pixel while idle must not be taken.
    setup(vecs[0]);
    for (int k = 0; k < 5; k++) step();
    chk("idle_no_consume", n_consumed, 0);

    for (int k = 0; k < 5; k++) run_frame(vecs[k]);

    // Reset in the middle of a frame, then a clean frame afterwards.
    setup(vecs[0]);
    start_next = 1'b1;
    i = 0;
    while (!(m_active && m_wr >= 16) && i < 200) begin
      step();
      i++;
    end
    chk("reached_write16", m_wr, 16);
    rst = 1'b1;
    #1;
    chk("midrst_wrreq", fif.wrreq, 1'b0);
    chk("midrst_ready", fif.ready_in, 1'b0);
    chk("midrst_data", fif.data_out, 32'h0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    m_active = 1'b0; m_since = 50; up_idx = 0; exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    run_frame(vecs[0]);

    // start while busy, start coincident with frame_done, then a start two
    // cycles after frame_done launching the next frame.
    setup(vecs[0]);
    f0 = m_frames;
    start_next = 1'b1;
    i = 0;
    while (!(m_active && m_wr >= 10) && i < 200) begin
      step();
      i++;
    end
    start_next = 1'b1;
    step();
    i = 0;
    while (!(m_active && m_wr >= TOTAL - 1) && i < 200) begin
      step();
      i++;
    end
    chk("reached_last_word", m_wr, TOTAL - 1);
    start_next = 1'b1;
    step();
    step();
    chk("done_start_ignored", busy, 1'b0);
    chk("first_frame_writes", n_writes, TOTAL);
    start_next = 1'b1;
    step();
    wait_frames(f0 + 2);
    step();
    step();
    chk("two_frame_writes", n_writes, 2 * TOTAL);
    chk("two_frame_done", n_done, 2);
    check_gold("second");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/featuremap_pad_writer.md
Name: featuremap_pad_writer

Overview:
- Producer end of a per-channel feature-map FIFO (writes with wrreq/full); the conv2D featuremap stage is the reader.
- Accepts one channel's unpadded raster stream (HEIGHT rows × WIDTH pixels, IEEE-754 single) from the previous layer.
- Writes a zero-bordered (HEIGHT+2)×(WIDTH+2) frame into the FIFO, in the order the 3×3 conv2D line buffer consumes it (WIDTH+2 per row).
- One instance per channel; 16 instances feed a 16-channel featuremap stage.

Parameters:
- DATA_WIDTH, 32, word width (float32).
- WIDTH, 56, unpadded pixels per row.
- HEIGHT, 56, unpadded rows per frame.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- data_in  in  DATA_WIDTH  unpadded pixel from upstream.
- valid_in  in  1  data_in valid.
- ready_in  out  1  pixel accepted this cycle when valid_in & ready_in.
- fifo_full  in  1  downstream FIFO full.
- wrreq  out  1  FIFO write strobe.
- data_out  out  DATA_WIDTH  FIFO write data.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after last padded word written.

Behaviour:
- Reset (async, rst=1): state=IDLE, row=0, col=0, frame_done=0, busy=0. Combinational outputs evaluate to ready_in=0, wrreq=0, data_out=0.
- Counters: col 0..WIDTH+1, row 0..HEIGHT+1. Width is clog2(WIDTH+2) / clog2(HEIGHT+2).
- border = (row==0) | (row==HEIGHT+1) | (col==0) | (col==WIDTH+1). interior = ~border.
- FSM states:
  - IDLE: start=1 → STREAM with row=col=0. Otherwise stay. start is ignored outside IDLE.
  - STREAM: busy=1.
    - wrreq = ~fifo_full & (border | valid_in). Combinational, zero latency.
    - data_out = border ? 0 (+0.0, all bits zero) : data_in.
    - ready_in = interior & ~fifo_full.
    - When wrreq=1, advance: col++. At col==WIDTH+1, col←0 and row++.
    - Write of (row=HEIGHT+1, col=WIDTH+1) → DONE.
  - DONE: frame_done=1 for exactly one cycle, busy=0, → IDLE.
- Hold conditions:
  - fifo_full=1: no write and no advance. ready_in=0, so an upstream pixel is held, not lost.
  - Interior position with valid_in=0: no write and no advance. Border words are written regardless of valid_in.
- Word count per frame is exactly (WIDTH+2)*(HEIGHT+2), with exactly WIDTH*HEIGHT pixels consumed.
- Upstream pixels presented outside interior positions are not consumed (ready_in=0).
- start in the same cycle as frame_done: ignored (the FSM is in DONE, not IDLE). A new frame needs start while in IDLE.
- rst mid-frame: immediately returns to IDLE, discarding the partial frame. The FIFO owner flushes it separately.
- Back-to-back frames: minimum 2 idle cycles between the last write and the first write of the next frame (DONE, IDLE).
- No arithmetic on data; pass-through only.

Decomposition:
- Shared package: FP32_ZERO constant, DATA_WIDTH default, and a state enum (IDLE/STREAM/DONE) encoded in 2 bits.
- One natural sub-module: featuremap_pad_counter. It holds the row/col counters with an advance enable, and outputs border and last.
- The FSM and muxing stay in the top.

Test Plan:
- Bench parameters WIDTH=4, HEIGHT=3; fifo_full=0; upstream always valid with pixels 1.0..12.0. Pulse start → 30 consecutive writes. Words 0–5 and 24–29 are 0. Row r (1..3) is 0, p, p+1, p+2, p+3, 0. Then frame_done pulses once, exactly 1 cycle after write 29; busy is low afterwards.
- Same stream but valid_in toggles 1,0 every cycle → still 30 writes with identical data order. No write while at an interior position with valid_in=0.
- fifo_full held high for 5 cycles starting at write 8 (interior pixel 2.0) → wrreq=0 and ready_in=0 throughout. Pixel 2.0 is written on the first cycle after full drops; no duplicate or missing words.
- Assert rst for 1 cycle after write 15 → outputs are 0 the same cycle, state IDLE. A new start yields a fresh 30-word frame beginning with 6 zeros.
- start while busy and start coincident with frame_done → ignored; write count stays 30. A start 2 cycles after frame_done launches the next frame.
- valid_in=1 while in IDLE or at a border position → ready_in=0 and the pixel is not consumed (checked against the upstream scoreboard).
